// File: rtl/nibble_packer_pkg.sv
// rtl/nibble_packer_pkg.sv - shared constants and record types for the nibble packer
package nibble_packer_pkg;

  localparam int   NIBBLE_W    = 4;
  localparam logic DEST_A      = 1'b0;
  localparam logic DEST_B      = 1'b1;
  localparam int   NIBBLES_DEF = 8;
  localparam int   WORD_W_DEF  = NIBBLE_W * NIBBLES_DEF;

  // Output buffer record at the default word width.
  typedef struct packed {
    logic [WORD_W_DEF-1:0] word;
    logic                  dest;
    logic                  full;
  } out_rec_t;

endpackage

// File: rtl/nibble_out_buf.sv
// rtl/nibble_out_buf.sv - single-entry output register with A/B valid/ready demux
module nibble_out_buf
  import nibble_packer_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              load_dest,
  input  logic              readyA,
  input  logic              readyB,
  output logic [WORD_W-1:0] dataA,
  output logic              validA,
  output logic [WORD_W-1:0] dataB,
  output logic              validB,
  output logic              full,
  output logic              out_fire
);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              dest;
    logic              full;
  } buf_rec_t;

  buf_rec_t rec;

  // load is only raised by the packer when the entry is empty or draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec <= '0;
    end else if (load) begin
      rec <= '{word: load_word, dest: load_dest, full: 1'b1};
    end else if (out_fire) begin
      rec <= '0;
    end
  end

  always_comb begin
    validA   = rec.full && (rec.dest == DEST_A);
    validB   = rec.full && (rec.dest == DEST_B);
    dataA    = validA ? rec.word : '0;
    dataB    = validB ? rec.word : '0;
    full     = rec.full;
    out_fire = (validA && readyA) || (validB && readyB);
  end

endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs a nibble stream LSN-first into words for two destinations
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int POS_W   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NIBBLE_W-1:0]         nibbleIn,
  input  logic                        nibbleValid,
  output logic                        nibbleReady,
  input  logic                        sel,
  input  logic                        flush,
  output logic [NIBBLE_W*NIBBLES-1:0] dataA,
  output logic                        validA,
  input  logic                        readyA,
  output logic [NIBBLE_W*NIBBLES-1:0] dataB,
  output logic                        validB,
  input  logic                        readyB,
  output logic [POS_W-1:0]            pos
);

  localparam int               WORD_W   = NIBBLE_W * NIBBLES;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NIBBLES - 1);

  logic [WORD_W-1:0] acc, acc_next;
  logic              acc_dest, dest_next;
  logic              flush_pending, pend_next;
  logic              buf_full, out_fire;
  logic              at_last, fire, completing, do_load;

  always_comb begin
    at_last     = (pos == LAST_POS);
    nibbleReady = !reset && !(at_last && buf_full && !out_fire);
    fire        = nibbleValid && nibbleReady;
    completing  = fire && at_last;

    acc_next  = acc;
    dest_next = acc_dest;
    if (fire) begin
      acc_next[int'(pos)*NIBBLE_W +: NIBBLE_W] = nibbleIn;
      if (pos == '0) dest_next = sel;
    end

    // A same-cycle nibble makes an otherwise-empty flush meaningful.
    pend_next = flush_pending || (flush && (fire || pos != '0));
    do_load   = completing || (pend_next && (!buf_full || out_fire));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos           <= '0;
      acc           <= '0;
      acc_dest      <= DEST_A;
      flush_pending <= 1'b0;
    end else if (do_load) begin
      pos           <= '0;
      acc           <= '0;
      acc_dest      <= dest_next;
      flush_pending <= 1'b0;
    end else begin
      acc           <= acc_next;
      acc_dest      <= dest_next;
      flush_pending <= pend_next;
      if (fire) pos <= pos + 1'b1;
    end
  end

  nibble_out_buf #(.WORD_W(WORD_W)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (do_load),
    .load_word (acc_next),
    .load_dest (dest_next),
    .readyA    (readyA),
    .readyB    (readyB),
    .dataA     (dataA),
    .validA    (validA),
    .dataB     (dataB),
    .validB    (validB),
    .full      (buf_full),
    .out_fire  (out_fire)
  );

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - directed bench with a queue-based reference model for nibble_packer
module tb_nibble_packer;

  localparam int N = 8;

  logic        clk, reset;
  logic [3:0]  nibbleIn;
  logic        nibbleValid, nibbleReady, sel, flush;
  logic [31:0] dataA, dataB;
  logic        validA, readyA, validB, readyB;
  logic [2:0]  pos;

  nibble_packer dut (
    .clk         (clk),
    .reset       (reset),
    .nibbleIn    (nibbleIn),
    .nibbleValid (nibbleValid),
    .nibbleReady (nibbleReady),
    .sel         (sel),
    .flush       (flush),
    .dataA       (dataA),
    .validA      (validA),
    .readyA      (readyA),
    .dataB       (dataB),
    .validB      (validB),
    .readyB      (readyB),
    .pos         (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: nibbles held, pending flush, one-word buffer.
  int          nib_q[$];
  logic        m_dest, m_pend, m_full, m_bdest;
  logic [31:0] m_bword;
  bit          armed = 0;
  logic [32:0] log_q[$];

  function automatic logic [31:0] pack_word();
    logic [31:0] w;
    w = '0;
    foreach (nib_q[k]) w = w | (32'(nib_q[k]) << (4 * k));
    return w;
  endfunction

  logic        e_ofire, e_ready, e_fire, e_free;
  logic [31:0] e_dataA, e_dataB;

  always @(negedge clk) begin
    if (armed) begin
      e_ofire = m_full && (m_bdest ? readyB : readyA);
      e_ready = !reset && !(nib_q.size() == N-1 && m_full && !e_ofire);
      e_dataA = (m_full && !m_bdest) ? m_bword : 32'h0;
      e_dataB = (m_full &&  m_bdest) ? m_bword : 32'h0;
      check("nibbleReady", 64'(nibbleReady), 64'(e_ready));
      check("validA", 64'(validA), 64'(m_full && !m_bdest));
      check("validB", 64'(validB), 64'(m_full && m_bdest));
      check("dataA", 64'(dataA), 64'(e_dataA));
      check("dataB", 64'(dataB), 64'(e_dataB));
      check("pos", 64'(pos), 64'(nib_q.size()));
      if (validA && readyA) log_q.push_back({1'b0, dataA});
      if (validB && readyB) log_q.push_back({1'b1, dataB});
    end
    if (reset) begin
      nib_q.delete();
      m_dest = 1'b0; m_pend = 1'b0; m_full = 1'b0; m_bdest = 1'b0; m_bword = '0;
      armed = 1;
    end else if (armed) begin
      e_fire = nibbleValid && e_ready;
      e_free = !m_full || e_ofire;
      if (e_ofire) m_full = 1'b0;
      if (e_fire) begin
        if (nib_q.size() == 0) m_dest = sel;
        nib_q.push_back(int'(nibbleIn));
      end
      if (flush && nib_q.size() > 0) m_pend = 1'b1;
      if (nib_q.size() == N || (m_pend && e_free)) begin
        m_full  = 1'b1;
        m_bword = pack_word();
        m_bdest = m_dest;
        nib_q.delete();
        m_pend  = 1'b0;
      end
    end
  end

  task automatic send(input logic [3:0] n, input logic s, input logic f);
    bit took;
    took        = 0;
    nibbleValid = 1'b1;
    nibbleIn    = n;
    sel         = s;
    flush       = f;
    for (int c = 0; c < 200 && !took; c++) begin
      @(negedge clk);
      took = nibbleReady;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end
  endtask

  task automatic idle(input int n);
    nibbleValid = 1'b0;
    flush       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    nibbleValid = 1'b0;
    flush       = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [32:0] exp);
    logic [32:0] got;
    got = (idx < log_q.size()) ? log_q[idx] : 33'hx;
    check(name, 64'(got), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; nibbleIn = '0; nibbleValid = 1'b0; sel = 1'b0; flush = 1'b0;
    readyA = 1'b1; readyB = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_pos", 64'(pos), 64'd0);
    check("reset_validA", 64'(validA), 64'd0);
    check("reset_validB", 64'(validB), 64'd0);
    check("reset_dataA", 64'(dataA), 64'd0);

    // Plain word to A.
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, 1'b0);
    idle(3);
    check_log("word_A_basic", 0, {1'b0, 32'h87654321});

    // sel only matters on the first nibble.
    for (int i = 0; i < 8; i++) send((i == 7) ? 4'hF : 4'h0, (i == 0) ? 1'b1 : 1'(i), 1'b0);
    idle(3);
    check_log("word_B_sel", 1, {1'b1, 32'hF0000000});

    // Partial flush, then an empty flush that must do nothing.
    send(4'hA, 1'b0, 1'b0);
    send(4'hB, 1'b1, 1'b0);
    send(4'hC, 1'b1, 1'b0);
    pulse_flush();
    idle(2);
    pulse_flush();
    idle(3);
    check_log("word_flush_partial", 2, {1'b0, 32'h00000CBA});
    check("log_after_empty_flush", 64'(log_q.size()), 64'd3);

    // Backpressure: 16 nibbles with A stalled, released mid-stall.
    readyA = 1'b0;
    fork
      for (int i = 0; i < 16; i++) send(4'(15 - i), 1'b0, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1 readyA = 1'b1;
      end
    join
    idle(4);
    check_log("word_stall_1", 3, {1'b0, 32'h89ABCDEF});
    check_log("word_stall_2", 4, {1'b0, 32'h01234567});

    // Flush together with the completing nibble.
    for (int i = 0; i < 8; i++) send(4'((2 * i + 2) & 15), 1'b0, (i == 7) ? 1'b1 : 1'b0);
    idle(4);
    check_log("word_flush_on_last", 5, {1'b0, 32'h0ECA8642});
    check("log_no_extra_word", 64'(log_q.size()), 64'd6);

    // Reset with a word stuck on B and a partial word in progress.
    readyB = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(4'h5, 1'b0, 1'b0);
    idle(1);
    check("pre_reset_pos", 64'(pos), 64'd5);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("post_reset_validB", 64'(validB), 64'd0);
    check("post_reset_dataB", 64'(dataB), 64'd0);
    check("post_reset_pos", 64'(pos), 64'd0);
    readyB = 1'b1;
    send(4'h9, 1'b0, 1'b0);
    send(4'hA, 1'b1, 1'b0);
    send(4'hB, 1'b1, 1'b0);
    send(4'hC, 1'b0, 1'b0);
    send(4'hD, 1'b0, 1'b0);
    send(4'hE, 1'b0, 1'b0);
    send(4'hF, 1'b0, 1'b0);
    send(4'h1, 1'b0, 1'b0);
    idle(4);
    check_log("word_after_reset", 6, {1'b0, 32'h1FEDCBA9});
    check("log_count", 64'(log_q.size()), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
